// File: rtl/mdio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdio_pkg
// Description : Shared constants and FSM state type for the MDIO link monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package mdio_pkg;

    localparam logic [1:0] SPD_10M     = 2'b00;
    localparam logic [1:0] SPD_100M    = 2'b01;
    localparam logic [1:0] SPD_1000M   = 2'b10;
    localparam logic [1:0] SPD_UNKNOWN = 2'b11;

    localparam logic [1:0] MDIO_ST     = 2'b01;
    localparam logic [1:0] MDIO_OP_RD  = 2'b10;
    localparam logic [1:0] MDIO_OP_WR  = 2'b01;
    localparam logic [1:0] MDIO_TA_WR  = 2'b10;

    typedef enum logic [3:0] {
        ST_POR_WAIT, ST_INIT, ST_SEL, ST_RD_STAT, ST_CHK_STAT, ST_RD_SPD,
        ST_CHK_SPD, ST_UNLINK, ST_UPDATE, ST_NEXT, ST_WAIT
    } mon_state_e;

    // One-hot vendor code to speed field; anything not strictly one-hot is unknown.
    function automatic logic [1:0] spd_decode(input logic [2:0] code);
        case (code)
            3'b100:  spd_decode = SPD_1000M;
            3'b010:  spd_decode = SPD_100M;
            3'b001:  spd_decode = SPD_10M;
            default: spd_decode = SPD_UNKNOWN;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_frame.sv
`default_nettype none
// ============================================================================
// Module      : mdio_frame
// Description : MDC divider and clause-22 serial shifter; write path only when
//               MDIO_LINK_MON_INIT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_frame #(
    parameter int HALF = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [4:0]  phyad_i,
    input  logic [4:0]  regad_i,
    input  logic [15:0] wdata_i,
    input  logic        mdio_i,
    output logic [15:0] rdata_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_oe_o
);
    import mdio_pkg::*;

    localparam int            HW        = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);
    localparam logic [6:0]    BIT_TA    = 7'd46;
    localparam logic [6:0]    BIT_DATA  = 7'd48;
    localparam logic [6:0]    BIT_IDLE  = 7'd64;

    logic [HW-1:0] half_q;
    logic [6:0]    bit_q;
    logic [63:0]   tx_q;
    logic [15:0]   rx_q;
    logic          busy_q, done_q, mdc_q, mdo_q, oe_q, wr_q;

    logic [1:0]    w_op;
    logic          w_wr;
    logic [15:0]   w_wdata;
    logic [63:0]   w_frame;
    logic [6:0]    w_nbit;

`ifdef MDIO_LINK_MON_INIT_EN
    assign w_wr    = wr_i;
    assign w_op    = wr_i ? MDIO_OP_WR : MDIO_OP_RD;
    assign w_wdata = wdata_i;
`else
    logic w_unused_wr;
    assign w_unused_wr = &{1'b0, wr_i, wdata_i};
    assign w_wr        = 1'b0;
    assign w_op        = MDIO_OP_RD;
    assign w_wdata     = 16'hFFFF;
`endif

    assign w_frame = {32'hFFFF_FFFF, MDIO_ST, w_op, phyad_i, regad_i, MDIO_TA_WR, w_wdata};
    assign w_nbit  = bit_q + 7'd1;

    // Bit k is launched on the MDC falling edge ending bit k-1 and sampled on the next rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q <= '0;
            bit_q  <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            mdc_q  <= 1'b0;
            mdo_q  <= 1'b1;
            oe_q   <= 1'b0;
            wr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (req_i) begin
                    busy_q <= 1'b1;
                    half_q <= '0;
                    bit_q  <= '0;
                    mdc_q  <= 1'b0;
                    tx_q   <= {w_frame[62:0], 1'b1};
                    mdo_q  <= w_frame[63];
                    oe_q   <= 1'b1;
                    wr_q   <= w_wr;
                end
            end else if (half_q != HALF_LAST) begin
                half_q <= half_q + HW'(1);
            end else begin
                half_q <= '0;
                mdc_q  <= ~mdc_q;
                if (!mdc_q) begin
                    if (bit_q >= BIT_DATA && bit_q < BIT_IDLE)
                        rx_q <= {rx_q[14:0], mdio_i};
                end else if (bit_q == BIT_IDLE) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    bit_q <= w_nbit;
                    tx_q  <= {tx_q[62:0], 1'b1};
                    mdo_q <= (w_nbit == BIT_IDLE) ? 1'b1 : tx_q[63];
                    oe_q  <= (w_nbit < BIT_TA) || (wr_q && (w_nbit < BIT_IDLE));
                end
            end
        end
    end

    assign rdata_o   = rx_q;
    assign done_o    = done_q;
    assign busy_o    = busy_q;
    assign mdc_o     = mdc_q;
    assign mdio_o    = mdo_q;
    assign mdio_oe_o = oe_q;

endmodule
`default_nettype wire

// File: rtl/mdio_link_monitor.sv
`default_nettype none
// ============================================================================
// Module      : mdio_link_monitor
// Description : Round-robin MDIO poller publishing per-PHY link/speed; the PHY
//               init write is built only with MDIO_LINK_MON_INIT_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_link_monitor #(
    parameter int          N_PHY         = 2,
    parameter logic [4:0]  PHY_ADDR_BASE = 5'd1,
    parameter int          REF_CLK_MHZ   = 50,
    parameter int          MDC_KHZ       = 500,
    parameter int          POR_WAIT_CYC  = 3_000_000,
    parameter int          POLL_CYC      = 50_000_000,
    parameter logic [4:0]  STAT_REG      = 5'd1,
    parameter logic [4:0]  SPEED_REG     = 5'd31,
    parameter int          SPEED_RETRY   = 3,
    parameter logic [15:0] INIT_DATA     = 16'h1340
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 mdc,
    output logic                 mdio_o,
    output logic                 mdio_oe,
    input  logic                 mdio_i,
    output logic [N_PHY-1:0]     link,
    output logic [2*N_PHY-1:0]   speed,
    output logic [N_PHY-1:0]     link_chg,
    output logic [N_PHY-1:0]     speed_err,
    output logic                 busy
);
    import mdio_pkg::*;

    localparam int HALF   = REF_CLK_MHZ * 1000 / (2 * MDC_KHZ);
    localparam int CH_W   = (N_PHY > 1) ? $clog2(N_PHY) : 1;
    localparam int POR_W  = (POR_WAIT_CYC > 1) ? $clog2(POR_WAIT_CYC) : 1;
    localparam int POLL_W = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
    localparam int RTY_W  = (SPEED_RETRY > 0) ? $clog2(SPEED_RETRY + 1) : 1;
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_PHY - 1);
    localparam logic [POR_W-1:0]  POR_LAST  = POR_W'(POR_WAIT_CYC - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYC - 1);
    localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(SPEED_RETRY);

    mon_state_e               state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [POR_W-1:0]         por_q, por_d;
    logic [POLL_W-1:0]        poll_q, poll_d;
    logic [RTY_W-1:0]         rty_q, rty_d;
    logic                     issued_q, issued_d;
    logic [15:0]              data_q, data_d;
    logic [N_PHY-1:0]         link_q, link_d;
    logic [N_PHY-1:0][1:0]    speed_q, speed_d;
    logic [N_PHY-1:0]         chg_q, chg_d;
    logic [N_PHY-1:0]         err_q, err_d;

    logic        w_req, w_wr, w_done;
    logic [4:0]  w_regad, w_phyad;
    logic [15:0] w_rdata;
    logic [1:0]  w_spd;
    logic        w_unused_data;

    assign w_phyad       = PHY_ADDR_BASE + 5'(ch_q);
    assign w_spd         = spd_decode(data_q[6:4]);
    assign w_unused_data = &{1'b0, data_q[15:7], data_q[3], data_q[1:0]};

    mdio_frame #(.HALF(HALF)) u_frame (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (w_req),
        .wr_i      (w_wr),
        .phyad_i   (w_phyad),
        .regad_i   (w_regad),
        .wdata_i   (INIT_DATA),
        .mdio_i    (mdio_i),
        .rdata_o   (w_rdata),
        .done_o    (w_done),
        .busy_o    (busy),
        .mdc_o     (mdc),
        .mdio_o    (mdio_o),
        .mdio_oe_o (mdio_oe)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_POR_WAIT;
            ch_q     <= '0;
            por_q    <= '0;
            poll_q   <= '0;
            rty_q    <= '0;
            issued_q <= 1'b0;
            data_q   <= '0;
            link_q   <= '0;
            speed_q  <= {N_PHY{SPD_UNKNOWN}};
            chg_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            por_q    <= por_d;
            poll_q   <= poll_d;
            rty_q    <= rty_d;
            issued_q <= issued_d;
            data_q   <= data_d;
            link_q   <= link_d;
            speed_q  <= speed_d;
            chg_q    <= chg_d;
            err_q    <= err_d;
        end
    end

    // issued_q marks a frame already requested in the current access state.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        por_d    = por_q;
        poll_d   = poll_q;
        rty_d    = rty_q;
        issued_d = issued_q;
        data_d   = data_q;
        link_d   = link_q;
        speed_d  = speed_q;
        chg_d    = '0;
        err_d    = err_q;
        w_req    = 1'b0;
        w_wr     = 1'b0;
        w_regad  = STAT_REG;
        case (state_q)
            ST_POR_WAIT: begin
                if (por_q == POR_LAST) begin
                    ch_d = '0;
`ifdef MDIO_LINK_MON_INIT_EN
                    state_d = ST_INIT;
`else
                    state_d = ST_SEL;
`endif
                end else begin
                    por_d = por_q + POR_W'(1);
                end
            end
`ifdef MDIO_LINK_MON_INIT_EN
            ST_INIT: begin
                w_wr    = 1'b1;
                w_regad = 5'd0;
                if (!issued_q) begin
                    w_req    = 1'b1;
                    issued_d = 1'b1;
                end else if (w_done) begin
                    issued_d = 1'b0;
                    if (ch_q == CH_LAST) state_d = ST_SEL;
                    else                 ch_d    = ch_q + CH_W'(1);
                end
            end
`endif
            ST_SEL: begin
                ch_d    = '0;
                state_d = ST_RD_STAT;
            end
            ST_RD_STAT: begin
                w_regad = STAT_REG;
                if (!issued_q) begin
                    w_req    = 1'b1;
                    issued_d = 1'b1;
                end else if (w_done) begin
                    issued_d = 1'b0;
                    data_d   = w_rdata;
                    state_d  = ST_CHK_STAT;
                end
            end
            ST_CHK_STAT: begin
                rty_d   = '0;
                state_d = data_q[2] ? ST_RD_SPD : ST_UNLINK;
            end
            ST_RD_SPD: begin
                w_regad = SPEED_REG;
                if (!issued_q) begin
                    w_req    = 1'b1;
                    issued_d = 1'b1;
                end else if (w_done) begin
                    issued_d = 1'b0;
                    data_d   = w_rdata;
                    state_d  = ST_CHK_SPD;
                end
            end
            ST_CHK_SPD: begin
                if (w_spd != SPD_UNKNOWN) begin
                    state_d = ST_UPDATE;
                end else if (rty_q != RTY_MAX) begin
                    rty_d   = rty_q + RTY_W'(1);
                    state_d = ST_RD_SPD;
                end else begin
                    err_d[ch_q] = 1'b1;
                    state_d     = ST_NEXT;
                end
            end
            ST_UNLINK: begin
                link_d[ch_q] = 1'b0;
                chg_d[ch_q]  = link_q[ch_q];
                state_d      = ST_NEXT;
            end
            ST_UPDATE: begin
                link_d[ch_q]  = 1'b1;
                speed_d[ch_q] = w_spd;
                err_d[ch_q]   = 1'b0;
                chg_d[ch_q]   = !link_q[ch_q] || (speed_q[ch_q] != w_spd);
                state_d       = ST_NEXT;
            end
            ST_NEXT: begin
                if (ch_q == CH_LAST) begin
                    poll_d  = '0;
                    state_d = ST_WAIT;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = ST_RD_STAT;
                end
            end
            ST_WAIT: begin
                if (poll_q == POLL_LAST) state_d = ST_SEL;
                else                     poll_d  = poll_q + POLL_W'(1);
            end
            default: state_d = ST_POR_WAIT;
        endcase
    end

    assign link      = link_q;
    assign speed     = speed_q;
    assign link_chg  = chg_q;
    assign speed_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mdio_link_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdio_link_monitor
// Description : Scoreboard bench with a two-PHY MDIO responder and a per-round
//               reference model of frames and published link/speed state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_link_monitor;

    localparam int N         = 2;
    localparam int HALF      = 2;
    localparam int POR       = 100;
    localparam int POLL      = 500;
    localparam int RETRY     = 3;
    localparam int FRAME_CYC = 130 * HALF;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           mdc, mdio_o, mdio_oe, mdio_i, busy;
    logic [N-1:0]   link, link_chg, speed_err;
    logic [2*N-1:0] speed;

    always #5 clk = ~clk;

    mdio_link_monitor #(
        .N_PHY(N), .PHY_ADDR_BASE(5'd1), .REF_CLK_MHZ(4), .MDC_KHZ(1000),
        .POR_WAIT_CYC(POR), .POLL_CYC(POLL), .SPEED_RETRY(RETRY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe),
        .mdio_i(mdio_i), .link(link), .speed(speed), .link_chg(link_chg),
        .speed_err(speed_err), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    typedef struct { logic wr; logic [4:0] phy; logic [4:0] regad; } exp_frame_t;
    typedef struct { logic [63:0] bits; logic [63:0] oe; int len; } obs_frame_t;
    exp_frame_t exp_q[$];
    obs_frame_t obs_q[$];

    logic [15:0] stat_r[N];
    logic [15:0] spd_r[N];
    int cyc = 0;
    int first_start = -1;
    int chg_cnt[N];

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    function automatic logic [15:0] phy_read(input logic [4:0] phy, input logic [4:0] ra);
        phy_read = 16'hFFFF;
        if (phy >= 5'd1 && phy <= 5'(N)) begin
            if (ra == 5'd1)  phy_read = stat_r[int'(phy) - 1];
            if (ra == 5'd31) phy_read = spd_r[int'(phy) - 1];
        end
    endfunction

    // PHY responder: captures master bits on MDC rise, drives read data after MDC fall.
    initial begin
        int bitn = 0;
        bit in_fr = 0;
        logic busy_p = 1'b0, mdc_p = 1'b0;
        int start_c = 0;
        logic [63:0] fb = '0, fo = '0;
        logic [15:0] rv;
        mdio_i = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_fr  = 0;
                mdio_i = 1'b1;
            end else begin
                if (busy && !busy_p) begin
                    in_fr = 1; bitn = 0; start_c = cyc; fb = '0; fo = '0;
                    if (first_start < 0) first_start = cyc;
                end
                if (in_fr && mdc && !mdc_p && bitn < 64) begin
                    fb[63-bitn] = mdio_o;
                    fo[63-bitn] = mdio_oe;
                    bitn++;
                end else if (in_fr && !mdc && mdc_p) begin
                    if (bitn >= 48 && bitn < 64 && fb[29:28] == 2'b10) begin
                        rv = phy_read(fb[27:23], fb[22:18]);
                        mdio_i = rv[63-bitn];
                    end else begin
                        mdio_i = 1'b1;
                    end
                end
                if (!busy && busy_p && in_fr) begin
                    in_fr = 0;
                    obs_q.push_back('{fb, fo, cyc - start_c});
                end
            end
            busy_p = busy;
            mdc_p  = mdc;
        end
    end

    // Scoreboard monitor: every completed frame is matched against the next expectation.
    initial begin
        obs_frame_t o;
        exp_frame_t e;
        logic [45:0] hdr;
        forever begin
            @(negedge clk);
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                if (exp_q.size() == 0) begin
                    chk("exp_frames_pending", 64'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    hdr = {32'hFFFF_FFFF, 2'b01, (e.wr ? 2'b01 : 2'b10), e.phy, e.regad};
                    chk("frame_hdr", 64'(o.bits[63:18]), 64'(hdr));
                    if (e.wr) begin
                        chk("wr_ta_data", 64'(o.bits[17:0]), 64'({2'b10, 16'h1340}));
                        chk("wr_oe", o.oe, {64{1'b1}});
                    end else begin
                        chk("rd_oe", o.oe, {{46{1'b1}}, 18'd0});
                    end
                    chk("frame_len", 64'(o.len), 64'(FRAME_CYC));
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++)
            if (link_chg[i] === 1'b1) chg_cnt[i]++;
    end

    logic       mlink[N];
    logic [1:0] mspd[N];
    logic       merr[N];
    int         exp_chg[N];

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            mlink[c] = 1'b0; mspd[c] = 2'b11; merr[c] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic push_init_writes();
`ifdef MDIO_LINK_MON_INIT_EN
        for (int c = 0; c < N; c++) exp_q.push_back('{1'b1, 5'(c + 1), 5'd0});
`endif
    endtask

    // Reference model: one round of polling from the current PHY register contents.
    task automatic plan_round();
        logic       old_l;
        logic [1:0] old_s, dec;
        logic [2:0] code;
        bit         valid;
        for (int c = 0; c < N; c++) begin
            old_l = mlink[c];
            old_s = mspd[c];
            exp_q.push_back('{1'b0, 5'(c + 1), 5'd1});
            if (!stat_r[c][2]) begin
                mlink[c] = 1'b0;
            end else begin
                code = spd_r[c][6:4];
                valid = 1;
                dec = 2'b11;
                if (code == 3'b100)      dec = 2'b10;
                else if (code == 3'b010) dec = 2'b01;
                else if (code == 3'b001) dec = 2'b00;
                else                     valid = 0;
                for (int k = 0; k < (valid ? 1 : 1 + RETRY); k++)
                    exp_q.push_back('{1'b0, 5'(c + 1), 5'd31});
                if (valid) begin
                    mlink[c] = 1'b1; mspd[c] = dec; merr[c] = 1'b0;
                end else begin
                    merr[c] = 1'b1;
                end
            end
            exp_chg[c] = (mlink[c] != old_l || mspd[c] != old_s) ? 1 : 0;
            chg_cnt[c] = 0;
        end
    endtask

    task automatic wait_round();
        int t = 0;
        int quiet = 0;
        while (!busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (quiet < 60 && t < 8000) begin
            @(negedge clk);
            quiet = busy ? 0 : quiet + 1;
            t++;
        end
        if (quiet < 60) begin
            checks++;
            errors++;
            $display("FAIL round_timeout actual_quiet=%0d required_quiet=60", quiet);
        end
    endtask

    task automatic check_round();
        for (int c = 0; c < N; c++) begin
            chk($sformatf("link[%0d]", c), 64'(link[c]), 64'(mlink[c]));
            chk($sformatf("speed[%0d]", c), 64'(speed[2*c +: 2]), 64'(mspd[c]));
            chk($sformatf("speed_err[%0d]", c), 64'(speed_err[c]), 64'(merr[c]));
            chk($sformatf("link_chg_pulses[%0d]", c), 64'(chg_cnt[c]), 64'(exp_chg[c]));
        end
        chk("frames_outstanding", 64'(exp_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mdc"}, 64'(mdc), 0);
        chk({tag, "_mdio_oe"}, 64'(mdio_oe), 0);
        chk({tag, "_mdio_o"}, 64'(mdio_o), 1);
        chk({tag, "_link"}, 64'(link), 0);
        chk({tag, "_speed"}, 64'(speed), 64'({2*N{1'b1}}));
        chk({tag, "_link_chg"}, 64'(link_chg), 0);
        chk({tag, "_speed_err"}, 64'(speed_err), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
    endtask

    task automatic randomize_phys();
        logic [15:0] s;
        for (int c = 0; c < N; c++) begin
            stat_r[c] = 16'($urandom) & 16'hFFFB;
            if ($urandom_range(0, 3) != 0) stat_r[c] = stat_r[c] | 16'h0004;
            case ($urandom_range(0, 5))
                0:       s = 16'h0040;
                1:       s = 16'h0020;
                2:       s = 16'h0010;
                3:       s = 16'h0000;
                4:       s = 16'h0060;
                default: s = 16'($urandom) & 16'h0070;
            endcase
            spd_r[c] = s | (16'($urandom) & 16'hFF8F);
        end
    endtask

    task automatic release_and_first_round();
        int rel;
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        first_start = -1;
        wait_round();
        chk("por_delay_met", 64'((first_start - rel) >= POR), 1);
        check_round();
    endtask

    initial begin
        int t;
        model_reset();
        stat_r[0] = 16'h0004; spd_r[0] = 16'h0040;
        stat_r[1] = 16'h0000; spd_r[1] = 16'h0040;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");

        push_init_writes();
        plan_round();
        release_and_first_round();

        stat_r[1] = 16'h0004; spd_r[1] = 16'h0020;
        plan_round();
        wait_round();
        check_round();

        spd_r[0] = 16'h0000;
        plan_round();
        wait_round();
        check_round();

        for (int r = 0; r < 6; r++) begin
            randomize_phys();
            plan_round();
            wait_round();
            check_round();
        end

        t = 0;
        while (!busy && t < 2000) begin
            @(posedge clk);
            t++;
        end
        repeat (40) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midframe_reset");
        repeat (3) @(posedge clk);
        model_reset();
        obs_q.delete();
        randomize_phys();
        push_init_writes();
        plan_round();
        release_and_first_round();

        randomize_phys();
        plan_round();
        wait_round();
        check_round();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
